// File: rtl/bus_initiator.sv
// bus_initiator: 386SX-style bus master. It turns one internal request into
// one T1/T2 bus cycle, with a wait-state timeout and hold/hlda bus release.
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | bus at idle values, accepting req or hold
// T1     | address phase, _ads low for exactly one clk
// T2     | data phase, waiting for _ready or the wait-state timeout
// HOLD   | bus released to an external master (hlda, bus_float high)
module bus_initiator #(
    parameter int WAIT_W   = 8,
    parameter int WAIT_MAX = 255
) (
    input  logic        clk,
    input  logic        _reset,
    input  logic        req,
    input  logic [22:0] req_addr,
    input  logic [15:0] req_wdata,
    input  logic [1:0]  req_be,
    input  logic        req_wr,
    input  logic        req_mio,
    input  logic        req_dc,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [15:0] rdata,
    output logic [22:0] a,
    output logic        _bhe,
    output logic        _ble,
    output logic        _ads,
    output logic        wr,
    output logic        dc,
    output logic        mio,
    output logic [15:0] dout,
    output logic        dout_oe,
    input  logic [15:0] din,
    input  logic        _ready,
    input  logic        hold,
    output logic        hlda,
    output logic        bus_float
);

    typedef enum logic [1:0] {S_IDLE, S_T1, S_T2, S_HOLD} state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [22:0]       r_addr;
    logic [15:0]       r_wdata;
    logic [1:0]        r_be;
    logic              r_wr;
    logic              r_mio;
    logic              r_dc;
    logic [WAIT_W-1:0] r_wait_cnt;
    logic [15:0]       r_rdata;
    logic              r_done;
    logic              r_err;

    logic              w_accept;
    logic              w_illegal;
    logic              w_ready_hit;
    logic              w_timeout;
    logic              w_drive;
    logic [WAIT_W-1:0] w_cnt_inc;

    // Hold is checked first, so a request only counts when hold is low.
    assign w_accept    = (r_state == S_IDLE) && !hold && req && (req_be != 2'b00);
    assign w_illegal   = (r_state == S_IDLE) && !hold && req && (req_be == 2'b00);
    assign w_ready_hit = (r_state == S_T2) && !_ready;
    assign w_cnt_inc   = r_wait_cnt + 1'b1;
    // A wait clock that brings the count to WAIT_MAX aborts; _ready low wins.
    assign w_timeout   = (r_state == S_T2) && _ready && (w_cnt_inc == WAIT_W'(WAIT_MAX));
    assign w_drive     = (r_state == S_T1) || (r_state == S_T2);

    // State register.
    always_ff @(posedge clk) begin
        if (!_reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (hold) begin
                    w_state_nxt = S_HOLD;
                end else if (w_accept) begin
                    w_state_nxt = S_T1;
                end
            end
            S_T1:   w_state_nxt = S_T2;
            S_T2: begin
                if (w_ready_hit || w_timeout) begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_HOLD: begin
                if (!hold) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Request latch, wait counter, read data and the done/err pulse.
    always_ff @(posedge clk) begin
        if (!_reset) begin
            r_addr     <= '0;
            r_wdata    <= '0;
            r_be       <= '0;
            r_wr       <= 1'b0;
            r_mio      <= 1'b0;
            r_dc       <= 1'b0;
            r_wait_cnt <= '0;
            r_rdata    <= '0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_done <= w_ready_hit || w_timeout || w_illegal;
            r_err  <= w_timeout || w_illegal;
            if (w_accept) begin
                r_addr  <= req_addr;
                r_wdata <= req_wdata;
                r_be    <= req_be;
                r_wr    <= req_wr;
                r_mio   <= req_mio;
                r_dc    <= req_dc;
            end
            if (r_state == S_T1) begin
                r_wait_cnt <= '0;
            end else if ((r_state == S_T2) && _ready) begin
                r_wait_cnt <= w_cnt_inc;
            end
            if (w_ready_hit && !r_wr) begin
                r_rdata <= din;
            end
        end
    end

    // Bus and status outputs; everything outside T1/T2 sits at idle values.
    always_comb begin
        _ads      = 1'b1;
        a         = '0;
        _bhe      = 1'b1;
        _ble      = 1'b1;
        wr        = 1'b0;
        dc        = 1'b0;
        mio       = 1'b0;
        dout      = '0;
        dout_oe   = 1'b0;
        busy      = w_drive;
        hlda      = (r_state == S_HOLD);
        bus_float = (r_state == S_HOLD);
        done      = r_done;
        err       = r_err;
        rdata     = r_rdata;
        if (w_drive) begin
            _ads    = (r_state != S_T1);
            a       = r_addr;
            _bhe    = ~r_be[1];
            _ble    = ~r_be[0];
            wr      = r_wr;
            dc      = r_dc;
            mio     = r_mio;
            dout    = r_wr ? r_wdata : 16'h0000;
            dout_oe = r_wr;
        end
    end

endmodule

// File: tb/tb_bus_initiator.sv
// Bench for bus_initiator: directed protocol cases followed by random
// transfers, all checked against a transaction-level expectation.
module tb_bus_initiator;

    localparam int WAIT_MAX = 4;

    logic        clk = 1'b0;
    logic        _reset;
    logic        req;
    logic [22:0] req_addr;
    logic [15:0] req_wdata;
    logic [1:0]  req_be;
    logic        req_wr;
    logic        req_mio;
    logic        req_dc;
    logic        busy;
    logic        done;
    logic        err;
    logic [15:0] rdata;
    logic [22:0] a;
    logic        _bhe;
    logic        _ble;
    logic        _ads;
    logic        wr;
    logic        dc;
    logic        mio;
    logic [15:0] dout;
    logic        dout_oe;
    logic [15:0] din;
    logic        _ready;
    logic        hold;
    logic        hlda;
    logic        bus_float;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [15:0] exp_rdata = 16'h0000;

    bus_initiator #(.WAIT_W(8), .WAIT_MAX(WAIT_MAX)) dut (
        .clk(clk), ._reset(_reset), .req(req), .req_addr(req_addr),
        .req_wdata(req_wdata), .req_be(req_be), .req_wr(req_wr),
        .req_mio(req_mio), .req_dc(req_dc), .busy(busy), .done(done),
        .err(err), .rdata(rdata), .a(a), ._bhe(_bhe), ._ble(_ble),
        ._ads(_ads), .wr(wr), .dc(dc), .mio(mio), .dout(dout),
        .dout_oe(dout_oe), .din(din), ._ready(_ready), .hold(hold),
        .hlda(hlda), .bus_float(bus_float)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: observed no finish, expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp_v);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic check_bus_idle(input string tag);
        chk({tag, "/_ads"}, _ads, 1);
        chk({tag, "/_bhe"}, _bhe, 1);
        chk({tag, "/_ble"}, _ble, 1);
        chk({tag, "/a"}, a, 0);
        chk({tag, "/wr"}, wr, 0);
        chk({tag, "/dc"}, dc, 0);
        chk({tag, "/mio"}, mio, 0);
        chk({tag, "/dout"}, dout, 0);
        chk({tag, "/dout_oe"}, dout_oe, 0);
    endtask

    task automatic check_reset_state(input string tag);
        check_bus_idle(tag);
        chk({tag, "/busy"}, busy, 0);
        chk({tag, "/done"}, done, 0);
        chk({tag, "/err"}, err, 0);
        chk({tag, "/hlda"}, hlda, 0);
        chk({tag, "/bus_float"}, bus_float, 0);
        chk({tag, "/rdata"}, rdata, 0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            tick();
            chk("idle_done", done, 0);
            chk("idle_err", err, 0);
            chk("idle_busy", busy, 0);
            chk("idle_ads", _ads, 1);
        end
    endtask

    task automatic set_req(input logic [22:0] ad, input logic [1:0] be, input logic w,
                           input logic m, input logic d, input logic [15:0] wd);
        req       = 1'b1;
        req_addr  = ad;
        req_be    = be;
        req_wr    = w;
        req_mio   = m;
        req_dc    = d;
        req_wdata = wd;
    endtask

    // Entered in the T1 clk; returns in the done clk. A transfer with
    // `waits` not-ready clocks terminates on T2 clk waits+1 unless that
    // exceeds WAIT_MAX, in which case it aborts after WAIT_MAX T2 clocks.
    task automatic finish_xfer(input logic [22:0] ad, input logic [1:0] be, input logic w,
                               input logic m, input logic d, input logic [15:0] wd,
                               input logic [15:0] dval, input int waits, input bit raise_hold);
        int t2;
        int exp_t2;
        bit timed_out;
        t2        = 0;
        timed_out = (waits >= WAIT_MAX);
        exp_t2    = timed_out ? WAIT_MAX : waits + 1;
        chk("t1_ads", _ads, 0);
        chk("t1_a", a, ad);
        chk("t1_bhe", _bhe, !be[1]);
        chk("t1_ble", _ble, !be[0]);
        chk("t1_wr", wr, w);
        chk("t1_mio", mio, m);
        chk("t1_dc", dc, d);
        chk("t1_dout_oe", dout_oe, w);
        chk("t1_dout", dout, w ? wd : 16'h0000);
        chk("t1_busy", busy, 1);
        chk("t1_done", done, 0);
        chk("t1_err", err, 0);
        chk("t1_hlda", hlda, 0);
        tick();
        for (int i = 0; i < WAIT_MAX + 4; i++) begin
            if (done === 1'b1) break;
            t2++;
            chk("t2_ads", _ads, 1);
            chk("t2_a", a, ad);
            chk("t2_bhe", _bhe, !be[1]);
            chk("t2_ble", _ble, !be[0]);
            chk("t2_wr", wr, w);
            chk("t2_dout_oe", dout_oe, w);
            chk("t2_dout", dout, w ? wd : 16'h0000);
            chk("t2_busy", busy, 1);
            chk("t2_err", err, 0);
            chk("t2_hlda", hlda, 0);
            if (raise_hold && t2 == 1) hold = 1'b1;
            _ready = (t2 > waits) ? 1'b0 : 1'b1;
            din    = (t2 > waits) ? dval : 16'($urandom);
            tick();
        end
        _ready = 1'b1;
        chk("t2_count", t2, exp_t2);
        chk("end_done", done, 1);
        chk("end_err", err, timed_out);
        if (!w && !timed_out) exp_rdata = dval;
        chk("end_rdata", rdata, exp_rdata);
        chk("end_busy", busy, 0);
        chk("end_hlda", hlda, 0);
        check_bus_idle("end");
    endtask

    // Presents a request in the current clk; returns in the done clk.
    task automatic do_xfer(input logic [22:0] ad, input logic [1:0] be, input logic w,
                           input logic m, input logic d, input logic [15:0] wd,
                           input logic [15:0] dval, input int waits, input bit raise_hold);
        set_req(ad, be, w, m, d, wd);
        tick();
        req = 1'b0;
        if (be == 2'b00) begin
            chk("ill_done", done, 1);
            chk("ill_err", err, 1);
            chk("ill_busy", busy, 0);
            chk("ill_rdata", rdata, exp_rdata);
            check_bus_idle("ill");
        end else begin
            finish_xfer(ad, be, w, m, d, wd, dval, waits, raise_hold);
        end
    endtask

    initial begin
        _reset = 1'b0; req = 1'b0; req_addr = '0; req_wdata = '0; req_be = '0;
        req_wr = 1'b0; req_mio = 1'b0; req_dc = 1'b0; din = '0; _ready = 1'b1;
        hold = 1'b0;
        tick();
        tick();
        check_reset_state("rst");
        _reset = 1'b1;
        idle(1);

        // Read, zero wait states.
        do_xfer(23'h000100, 2'b11, 1'b0, 1'b1, 1'b1, 16'h0000, 16'hBEEF, 0, 1'b0);
        idle(1);
        // Write low byte with three wait states.
        do_xfer(23'h0ABCDE, 2'b01, 1'b1, 1'b1, 1'b1, 16'h1234, 16'h0000, 3, 1'b0);
        idle(1);
        // Timeout on a read: rdata keeps 0xBEEF.
        do_xfer(23'h7FFFF0, 2'b11, 1'b0, 1'b1, 1'b0, 16'h0000, 16'h5555, 100, 1'b0);
        idle(1);

        // Hold and req together: hold wins, req stays pending.
        hold = 1'b1;
        set_req(23'h123456, 2'b10, 1'b0, 1'b0, 1'b1, 16'h0000);
        tick();
        chk("hold_hlda", hlda, 1);
        chk("hold_float", bus_float, 1);
        chk("hold_ads", _ads, 1);
        chk("hold_busy", busy, 0);
        tick();
        chk("hold2_hlda", hlda, 1);
        chk("hold2_ads", _ads, 1);
        check_bus_idle("hold2");
        hold = 1'b0;
        tick();
        chk("unhold_hlda", hlda, 0);
        chk("unhold_float", bus_float, 0);
        chk("unhold_ads", _ads, 1);
        tick();
        req = 1'b0;
        finish_xfer(23'h123456, 2'b10, 1'b0, 1'b0, 1'b1, 16'h0000, 16'hA5C3, 1, 1'b0);

        // Hold raised mid-T2: acknowledged only after done.
        idle(1);
        do_xfer(23'h00F00D, 2'b11, 1'b1, 1'b1, 1'b1, 16'hCAFE, 16'h0000, 2, 1'b1);
        tick();
        chk("late_hold_hlda", hlda, 1);
        chk("late_hold_float", bus_float, 1);
        chk("late_hold_done", done, 0);
        hold = 1'b0;
        tick();
        chk("late_unhold_hlda", hlda, 0);
        chk("late_unhold_float", bus_float, 0);

        // Illegal byte enables.
        do_xfer(23'h000200, 2'b00, 1'b0, 1'b1, 1'b1, 16'h0000, 16'h0000, 0, 1'b0);
        idle(1);

        // Back-to-back: second request presented during the done clk.
        do_xfer(23'h000300, 2'b10, 1'b0, 1'b1, 1'b1, 16'h0000, 16'h7E57, 0, 1'b0);
        do_xfer(23'h000302, 2'b11, 1'b1, 1'b1, 1'b1, 16'h9876, 16'h0000, 1, 1'b0);
        idle(1);

        // Reset during T2 of a write.
        set_req(23'h044444, 2'b11, 1'b1, 1'b1, 1'b1, 16'hDEAD);
        tick();
        req = 1'b0;
        tick();
        chk("pre_rst_busy", busy, 1);
        _reset = 1'b0;
        tick();
        exp_rdata = 16'h0000;
        check_reset_state("midrst");
        _reset = 1'b1;
        tick();
        chk("post_rst_done", done, 0);
        chk("post_rst_busy", busy, 0);
        do_xfer(23'h055555, 2'b11, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h3C3C, 0, 1'b0);

        // Random transfers.
        for (int k = 0; k < 40; k++) begin
            logic [22:0] r_ad;
            logic [1:0]  r_be;
            logic [15:0] r_wd;
            logic [15:0] r_dv;
            r_ad = 23'($urandom);
            r_be = 2'($urandom_range(0, 3));
            r_wd = 16'($urandom);
            r_dv = 16'($urandom);
            do_xfer(r_ad, r_be, 1'($urandom), 1'($urandom), 1'($urandom), r_wd, r_dv,
                    int'($urandom_range(0, 5)), 1'b0);
            idle(int'($urandom_range(0, 2)));
        end
        idle(1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/bus_initiator.md
Name: bus_initiator

Overview:
- Bus master that generates 386SX-style bus cycles toward an external responder: _ads strobe, a[23:1], _bhe/_ble, wr, dc, mio, then wait for _ready.
- Converts a simple single-request internal interface into one T1/T2 bus cycle per request.
- Includes a wait-state timeout and hold/hlda bus-release arbitration.
- Used as a CPU-side bus model for bench and bring-up, and as the master engine for future FPGA-side DMA.

Parameters:
WAIT_W, 8, width of the T2 wait-state counter
WAIT_MAX, 255, maximum T2 clocks without _ready before abort; must be < 2**WAIT_W

Ports:
clk  input  1  system clock, all logic on rising edge
_reset  input  1  synchronous active-low reset
req  input  1  request strobe, sampled only in IDLE
req_addr  input  23  word address [23:1]
req_wdata  input  16  write data
req_be  input  2  byte enables, [1]=high byte, [0]=low byte, active high
req_wr  input  1  1=write, 0=read
req_mio  input  1  1=memory, 0=I/O
req_dc  input  1  1=data, 0=code/control
busy  output  1  high from request acceptance until completion
done  output  1  one-clock completion pulse
err  output  1  valid with done; 1=timeout or illegal byte enables
rdata  output  16  read data, held until the next read completes
a  output  23  bus address [23:1]
_bhe  output  1  high byte enable, active low
_ble  output  1  low byte enable, active low
_ads  output  1  address strobe, active low
wr  output  1  bus write/read
dc  output  1  bus data/control
mio  output  1  bus memory/io
dout  output  16  bus write data
dout_oe  output  1  write data drive enable
din  input  16  bus read data
_ready  input  1  cycle terminate, active low
hold  input  1  external bus request
hlda  output  1  hold acknowledge
bus_float  output  1  1 = all bus outputs must be tristated by top level

Behaviour:
- Reset (_reset=0 at a clk edge): state=IDLE.
  - Bus outputs: _ads=1, _bhe=1, _ble=1, a=0, wr=0, dc=0, mio=0, dout=0, dout_oe=0.
  - Status outputs: busy=0, done=0, err=0, hlda=0, bus_float=0, rdata=0, wait counter=0.
  - A reset mid-cycle aborts the cycle: no done pulse.
- States: IDLE, T1, T2, HOLD.
- IDLE:
  - If hold=1, go to HOLD. Hold has priority over req.
  - Else if req=1 and req_be!=00, latch the request onto the bus outputs and go to T1; busy=1 from the next clk.
  - Else if req=1 and req_be=00, stay in IDLE and pulse done=1, err=1 on the next clk. No bus cycle is run.
- T1 (exactly 1 clk):
  - _ads=0.
  - a, _bhe=~be[1], _ble=~be[0], wr, dc, mio driven from the latched request.
  - If wr=1: dout=wdata and dout_oe=1, both held through T2.
  - Next state: T2, with the wait counter cleared.
- T2:
  - _ads=1; address, enables and control stay stable.
  - Each clk, sample _ready.
  - _ready=0: for a read, rdata<=din on this edge. Go to IDLE; next clk done=1, err=0, busy=0. All enables return to idle values: _bhe=_ble=1, dout_oe=0.
  - _ready=1: increment the counter. When the counter reaches WAIT_MAX, go to IDLE; next clk done=1, err=1, busy=0; rdata unchanged.
  - If _ready=0 arrives on the same clk the counter reaches WAIT_MAX, _ready wins (err=0).
- Minimum cycle: 2 clks (T1 + one T2).
- Back-to-back: a req accepted in the same clk that done is high gives one IDLE clk between bus cycles.
- HOLD:
  - Entered from IDLE only; hold during T1/T2 is ignored until the cycle completes.
  - hlda=1 and bus_float=1 from the clk after entry; bus outputs held at idle values.
  - When hold=0, go to IDLE; hlda=0 and bus_float=0 on the next clk.
  - req is ignored in HOLD and remains pending if the requester keeps it asserted.
- done is high for exactly 1 clk. err is 0 whenever done=0.

Test Plan:
- Read, zero wait: req_addr=0x000100, req_be=11, req_wr=0, req_mio=1; _ready=0 in first T2 with din=0xBEEF -> _ads low 1 clk with a=0x000100, _bhe=_ble=0; done one clk after the T2 sample; rdata=0xBEEF, err=0, 2-clk bus cycle.
- Write low byte, 3 waits: req_be=01, req_wdata=0x1234; _ready low on the 4th T2 clk -> _ble=0, _bhe=1, dout=0x1234 with dout_oe=1 from T1 through the last T2; done err=0; total 5 bus clks.
- Timeout: WAIT_MAX=4, _ready held high -> exactly 4 T2 clks, then done=1, err=1; rdata keeps its previous value; bus back to idle values.
- Arbitration: hold=1 and req=1 together in IDLE -> hlda=1, bus_float=1, no _ads. Drop hold -> hlda=0, then T1 for the pending req. Hold raised mid-T2 -> hlda only after done.
- Illegal enables: req_be=00 -> no _ads pulse; done=1, err=1 one clk later.
- Reset mid-cycle: _reset=0 during T2 of a write -> next clk all outputs at reset values, no done. A request issued afterwards runs normally.
